// File: rtl/pronoc_pkg.sv
// Shared NoC endpoint definitions: VC count, buffer depth, credit width,
// flit layout and the injection-arbiter FSM state type.
package pronoc_pkg;

    localparam int V     = 2;                  // virtual channels per port
    localparam int B     = 4;                  // downstream buffer depth per VC
    localparam int CRDTw = $clog2(B + 1);      // credit counter must hold 0..B
    localparam int DATAw = 16;                 // payload bits per flit

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } inj_arb_state_t;

    // One flit; vc is one-hot over the V virtual channels.
    typedef struct packed {
        logic             hdr_flag;
        logic             tail_flag;
        logic [V-1:0]     vc;
        logic [DATAw-1:0] data;
    } flit_t;

    localparam int Fw = $bits(flit_t);

endpackage

// File: rtl/endp_inj_vc_arbiter_chk.sv
// Credit-overflow checker for the injection arbiter: a credit return that is
// not offset by a grant must never push a VC above its initial credit.
module endp_inj_vc_arbiter_chk
    import pronoc_pkg::*;
(
    input logic               clk,
    input logic               reset,
    input logic               run,
    input logic [V*CRDTw-1:0] credit,
    input logic [V*CRDTw-1:0] init_val,
    input logic [V-1:0]       inc,
    input logic [V-1:0]       dec
);

    // Flag any net increment on a VC whose counter is already at its initial value.
    always @(posedge clk) begin
        if (!reset && run) begin
            for (int v = 0; v < V; v++) begin
                assert (!(inc[v] && !dec[v] &&
                          (credit[v*CRDTw +: CRDTw] >= init_val[v*CRDTw +: CRDTw])));
            end
        end
    end

endmodule

// File: rtl/inj_rr_arbiter.sv
// NREQ-wide one-hot round-robin arbiter. The search starts at the registered
// pointer; on a grant the pointer moves to the slot after the winner.
module inj_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   ptr_s;
    logic [NREQ-1:0] gnt_s;

    // Pick the first requester at or after the pointer and precompute the new pointer.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        int            sum;
        gnt_s = '0;
        ptr_s = ptr_r;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(ptr_r) + k;
            if (sum >= NREQ) begin
                idx = PW'(sum - NREQ);
            end else begin
                idx = PW'(sum);
            end
            if (req[idx] && !found) begin
                found      = 1'b1;
                gnt_s[idx] = 1'b1;
                ptr_s      = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
            end else begin
                found = found;
            end
        end
    end

    // Pointer register: advances only when a grant is actually issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (en && (|gnt_s)) begin
            ptr_r <= ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt = en ? gnt_s : '0;

endmodule

// File: rtl/endp_inj_vc_arbiter.sv
// Endpoint-to-router injection arbiter. Shares one flit channel between NREQ
// sources with per-VC credits and packet-atomic VC ownership.
// Optional: define PRONOC_INJ_ARB_STATS_EN to add stat_flits / stat_err counters.
module endp_inj_vc_arbiter
    import pronoc_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*Fw-1:0]  req_flit,
    output logic [NREQ-1:0]     req_ready,
    input  logic [V*CRDTw-1:0]  credit_init_val,
    input  logic [V-1:0]        credit_in,
    output logic [Fw-1:0]       flit_out,
    output logic                flit_wr,
    output logic [V-1:0]        vc_owned,
    output logic                err_body_no_owner
`ifdef PRONOC_INJ_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0]  stat_flits,
    output logic [15:0]         stat_err
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    inj_arb_state_t     state_r;
    inj_arb_state_t     state_s;
    logic [CRDTw-1:0]   credit_r [V];
    logic [V*CRDTw-1:0] credit_flat_s;
    logic [V-1:0]       credit_nz_s;
    logic [V-1:0]       owned_r;
    logic [PW-1:0]      owner_r [V];
    flit_t              req_flit_s [NREQ];
    logic [NREQ-1:0]    elig_s;
    logic [NREQ-1:0]    err_vec_s;
    logic [NREQ-1:0]    gnt_s;
    flit_t              gnt_flit_s;
    logic [PW-1:0]      gnt_idx_s;
    logic               gnt_any_s;
    logic [V-1:0]       dec_s;
    flit_t              flit_out_r;
    logic               flit_wr_r;
    logic               run_s;

    // Global state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: INIT lasts exactly one cycle (credit load), then RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            INIT:    state_s = RUN;
            RUN:     state_s = RUN;
            default: state_s = INIT;
        endcase
    end

    assign run_s = (state_r == RUN);

    // Unpack the flat flit bus and flatten credits for the checker.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_flit_s[i] = req_flit[i*Fw +: Fw];
        end
        for (int v = 0; v < V; v++) begin
            credit_flat_s[v*CRDTw +: CRDTw] = credit_r[v];
            credit_nz_s[v]                  = (credit_r[v] != '0);
        end
    end

    // Eligibility and protocol-error detection per requester.
    always_comb begin
        logic [V-1:0] own_mask;
        logic         has_credit;
        logic         vc_free;
        logic         mine;
        own_mask   = '0;
        has_credit = 1'b0;
        vc_free    = 1'b0;
        mine       = 1'b0;
        elig_s     = '0;
        err_vec_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int v = 0; v < V; v++) begin
                own_mask[v] = owned_r[v] && (owner_r[v] == PW'(i));
            end
            has_credit = |(req_flit_s[i].vc & credit_nz_s);
            vc_free    = ~|(req_flit_s[i].vc & owned_r);
            mine       = |(req_flit_s[i].vc & own_mask);
            if (run_s && req_valid[i]) begin
                if (req_flit_s[i].hdr_flag) begin
                    // A header from the owner would nest packets on one VC.
                    elig_s[i]    = vc_free && has_credit;
                    err_vec_s[i] = mine;
                end else begin
                    elig_s[i]    = mine && has_credit;
                    err_vec_s[i] = !mine;
                end
            end else begin
                elig_s[i]    = 1'b0;
                err_vec_s[i] = 1'b0;
            end
        end
    end

    inj_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (run_s),
        .req   (elig_s),
        .gnt   (gnt_s)
    );

    // Winner flit and index; grant is one-hot so an OR-mux is exact.
    always_comb begin
        gnt_flit_s = '0;
        gnt_idx_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_flit_s = gnt_flit_s | ({Fw{gnt_s[i]}} & req_flit_s[i]);
            gnt_idx_s  = gnt_idx_s  | ({PW{gnt_s[i]}} & PW'(i));
        end
        gnt_any_s = |gnt_s;
        dec_s     = gnt_any_s ? gnt_flit_s.vc : '0;
    end

    // Per-VC credit counters: load in INIT, then +return / -grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                credit_r[v] <= '0;
            end
        end else if (state_r == INIT) begin
            for (int v = 0; v < V; v++) begin
                credit_r[v] <= credit_init_val[v*CRDTw +: CRDTw];
            end
        end else begin
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !dec_s[v]) begin
                    credit_r[v] <= credit_r[v] + CRDTw'(1);
                end else if (!credit_in[v] && dec_s[v]) begin
                    credit_r[v] <= credit_r[v] - CRDTw'(1);
                end else begin
                    credit_r[v] <= credit_r[v];
                end
            end
        end
    end

    // VC ownership: taken by a multi-flit header, released by its tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owned_r <= '0;
            for (int v = 0; v < V; v++) begin
                owner_r[v] <= '0;
            end
        end else if (gnt_any_s) begin
            for (int v = 0; v < V; v++) begin
                if (gnt_flit_s.vc[v] && gnt_flit_s.hdr_flag && !gnt_flit_s.tail_flag) begin
                    owned_r[v] <= 1'b1;
                    owner_r[v] <= gnt_idx_s;
                end else if (gnt_flit_s.vc[v] && gnt_flit_s.tail_flag && !gnt_flit_s.hdr_flag) begin
                    owned_r[v] <= 1'b0;
                end else begin
                    owned_r[v] <= owned_r[v];
                end
            end
        end else begin
            owned_r <= owned_r;
        end
    end

    // Output register: granted flit appears the cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_out_r <= '0;
            flit_wr_r  <= 1'b0;
        end else begin
            flit_wr_r <= gnt_any_s;
            if (gnt_any_s) begin
                flit_out_r <= gnt_flit_s;
            end else begin
                flit_out_r <= flit_out_r;
            end
        end
    end

    assign req_ready         = gnt_s;
    assign flit_out          = flit_out_r;
    assign flit_wr           = flit_wr_r;
    assign vc_owned          = owned_r;
    assign err_body_no_owner = |err_vec_s;

`ifdef PRONOC_INJ_ARB_STATS_EN
    logic [31:0] stat_flits_r [NREQ];
    logic [15:0] stat_err_r;

    // Saturating per-requester accepted-flit and error-pulse counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_flits_r[i] <= '0;
            end
            stat_err_r <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_s[i] && (stat_flits_r[i] != 32'hFFFF_FFFF)) begin
                    stat_flits_r[i] <= stat_flits_r[i] + 32'd1;
                end else begin
                    stat_flits_r[i] <= stat_flits_r[i];
                end
            end
            if (err_body_no_owner && (stat_err_r != 16'hFFFF)) begin
                stat_err_r <= stat_err_r + 16'd1;
            end else begin
                stat_err_r <= stat_err_r;
            end
        end
    end

    // Flatten the per-requester counters onto the output bus.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_flits[i*32 +: 32] = stat_flits_r[i];
        end
        stat_err = stat_err_r;
    end
`endif

    endp_inj_vc_arbiter_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .run      (run_s),
        .credit   (credit_flat_s),
        .init_val (credit_init_val),
        .inc      (credit_in),
        .dec      (dec_s)
    );

endmodule

// File: doc/endp_inj_vc_arbiter.md
# endp_inj_vc_arbiter

Shares one endpoint-to-router injection flit channel between NREQ local traffic sources. The block sits between the endpoint's packet sources and the router's local input port. It tracks downstream buffer credits per VC and enforces packet-atomic VC ownership: once a header is granted on a VC, that VC carries only the owner's flits until its tail. Among eligible requesters it grants one flit per cycle, in round-robin order.

## Interface
- NREQ, 4: number of requesters (≥2).
- V, package V: virtual channels per port.
- B, package B: downstream buffer depth per VC; credit counters are CRDTw bits wide.
- clk, in, 1: clock.
- reset, in, 1: reset; one clock, asynchronous, active-high.
- req_valid, in, NREQ: requester i presents a flit.
- req_flit, in, NREQ×Fw: flit_t per requester; `vc` is one-hot.
- req_ready, out, NREQ: flit i is accepted this cycle. The transfer occurs when req_valid[i] & req_ready[i].
- credit_init_val, in, V×CRDTw: initial credit per VC, taken from ctrl_chanel.
- credit_in, in, V: downstream returns one credit on VC v.
- flit_out, out, Fw: the granted flit, registered.
- flit_wr, out, 1: flit_out is valid.
- vc_owned, out, V: the VC is mid-packet, owned by a requester.
- err_body_no_owner, out, 1: pulse when a requester presents a non-header flit on a VC it does not own.

## Operation
- Global FSM states: INIT, RUN.
  - INIT: entered on reset. In the first cycle after reset deasserts, every credit counter loads credit_init_val, then the FSM moves to RUN.
  - No grants are issued while in INIT.
- Eligibility of requester i in RUN: req_valid[i], the flit's VC v has credit[v] > 0, and one of:
  - hdr_flag=1 and VC v is free;
  - VC v is owned by i. A header from the current owner is treated as a protocol error: not eligible, err pulses.
- Arbitration:
  - One-hot round-robin over the eligible set; at most one grant per cycle.
  - The pointer moves to the position after the winner on every grant and holds otherwise.
  - req_ready is one-hot or zero and combinational from the eligibility logic.
- Ownership update on a grant:
  - header without tail: owner[v] ← i, vc_owned[v] ← 1;
  - tail: vc_owned[v] ← 0;
  - single-flit packet (hdr & tail): ownership is never taken.
- Credits:
  - A grant on VC v decrements credit[v].
  - credit_in[v] increments credit[v].
  - A grant and a credit return on the same VC in the same cycle leave it unchanged.
  - Overflow past credit_init_val is an assertion failure.
  - Underflow cannot occur, because eligibility requires credit > 0.
- A non-header flit on an unowned VC, or on a VC owned by another requester, is never granted and raises err_body_no_owner for that cycle.

## Timing
- Reset values: flit_wr=0, flit_out=0, req_ready=0, vc_owned=0, err_body_no_owner=0. Credits are 0, the RR pointer is 0, and the FSM is in INIT.
- Latency: accepted in cycle t → flit_wr=1 with that flit in cycle t+1.
- Sustained throughput: 1 flit/cycle while any requester is eligible.
- Credit returned in cycle t → usable for a grant in cycle t+1.
- Reset asserted mid-packet clears all ownership and credits immediately. The partial packet is abandoned.

## Configuration
- PRONOC_INJ_ARB_STATS_EN defined:
  - adds output stat_flits (NREQ×32), per-requester accepted-flit counters, saturating at 2^32−1;
  - adds output stat_err (16), a saturating count of err_body_no_owner pulses;
  - both reset to 0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package (pronoc_pkg) holds:
  - the inj_arb_state_t enum (INIT, RUN);
  - the CRDTw width;
  - the flit_t typedef.
- One sub-module: inj_rr_arbiter, an NREQ-wide one-hot round-robin arbiter with a registered pointer and an enable-on-grant update.
- Credit counters, ownership registers and the output register stay in the top module.

## Test plan
- Init load: credit_init_val={4,4}. After reset release, no grant in the INIT cycle. Then requester 0 sends 4 single-flit packets on VC0 → 4 flits out; the 5th is held until credit_in[0] pulses, and is out 2 cycles after that pulse.
- Round-robin: all 4 requesters valid with single-flit packets on VC1 and ample credit → grant order 0,1,2,3,0 on consecutive cycles.
- Ownership:
  - requester 1 sends a 3-flit packet on VC0 while requester 2 presents a header on VC0 → requester 2 is stalled until the cycle after requester 1's tail is accepted;
  - requester 2 can interleave on VC1 meanwhile.
- Simultaneous events: a grant and credit_in on the same VC in the same cycle → credit unchanged. A credit_in beyond the init value → assertion fires.
- Protocol error: a body flit on an unowned VC → never granted, err_body_no_owner=1 while presented. With PRONOC_INJ_ARB_STATS_EN, stat_err increments once per cycle presented.
- Reset mid-packet: reset asserted after the header of a 4-flit packet → vc_owned=0 and flit_wr=0 immediately. After release, INIT reloads credits and a fresh header is accepted.
